arr_mem_fifo: RTL and testbench
===============================

ARR_MEM_FIFO -- requirements
Module: arr_mem_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default $clog2(DEPTH), pointer width (derived, not overridden).
REQ-003 SHALL have CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have I_VALID  input  1  producer offers entry.
REQ-006 SHALL have I_READY  output  1  FIFO accepts entry this cycle.
REQ-007 SHALL have I_DATA_0_X / I_DATA_1_X  input  1 each  element X fields.
REQ-008 SHALL have I_DATA_0_Y / I_DATA_1_Y  input  5 each  element Y fields.
REQ-009 SHALL have O_VALID  output  1  head entry available.
REQ-010 SHALL have O_READY  input  1  consumer takes head entry.
REQ-011 SHALL have O_DATA_0_X / O_DATA_1_X  output  1 each; O_DATA_0_Y / O_DATA_1_Y  output  5 each  head entry fields.
REQ-012 SHALL have COUNT  output  ADDR_W+1  occupied entries.

Function
REQ-013 Push SHALL occur when I_VALID && I_READY; pop SHALL occur when O_VALID && O_READY.
REQ-014 I_READY SHALL equal (COUNT != DEPTH); no pass-through when full, even with simultaneous pop.
REQ-015 O_VALID SHALL equal (COUNT != 0); O_DATA SHALL be don't-care when O_VALID=0.
REQ-016 Storage word SHALL be 12 bits packed: bit0 = 0_X, bits5:1 = 0_Y, bit6 = 1_X, bits11:7 = 1_Y.
REQ-017 Push SHALL write packed word at wptr on the same edge and increment wptr modulo DEPTH.
REQ-018 Storage read SHALL be asynchronous; O_DATA SHALL reflect mem[rptr] combinationally; push-to-O_VALID latency SHALL be 1 cycle.
REQ-019 Pop SHALL increment rptr modulo DEPTH; entry order SHALL be strictly FIFO.
REQ-020 COUNT SHALL update: +1 push only, -1 pop only, unchanged on both or neither.
REQ-021 Simultaneous push and pop at 0 < COUNT < DEPTH SHALL advance both pointers and leave COUNT unchanged.
REQ-022 Pointer wrap from DEPTH-1 to 0 SHALL not disturb COUNT or data order.
REQ-023 Full/empty SHALL derive from COUNT only, never from pointer equality.

Reset
REQ-024 RESET=1 at an edge SHALL set wptr=0, rptr=0, COUNT=0, giving O_VALID=0, I_READY=1.
REQ-025 RESET SHALL dominate push/pop in the same cycle; storage contents SHALL not be cleared.
REQ-026 While RESET=1, I_READY SHALL be 0.

Configuration
REQ-027 Macro ARR_MEM_FIFO_BLOCKED_EN SHALL add output BLOCKED (1 bit).
REQ-028 With the macro, BLOCKED SHALL set on any edge where I_VALID && !I_READY, stay set until RESET, and reset to 0.
REQ-029 Without the macro, port BLOCKED and its register SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 Package arr_mem_fifo_pkg SHALL hold ELEM_Y_W=5, ELEM_W=6, N_ELEM=2, WORD_W=12, elem_t {x, y}, the word typedef, and pack/unpack functions.
REQ-031 Storage SHALL be one sub-module arr_mem_fifo_mem (DEPTH x WORD_W, synchronous write, asynchronous read, no init).
REQ-032 Top SHALL contain only pointers, COUNT, handshake logic, packing and the optional BLOCKED flag.

Verification
REQ-033 Reset, then idle: COUNT=0, O_VALID=0, I_READY=1 (I_READY=0 during RESET).
REQ-034 Push {0_X=1,0_Y=5'h15,1_X=0,1_Y=5'h0A}, O_READY=0: O_VALID=1 next cycle; O_DATA matches; packed word 12'h52B.
REQ-035 Push 4 entries, O_READY=0: COUNT=4, I_READY=0; 5th I_VALID not accepted; BLOCKED=1 if enabled.
REQ-036 Full FIFO, I_VALID=1 and O_READY=1 same cycle: pop only, COUNT=3; push accepted next cycle.
REQ-037 Continuous push and pop of 10 incrementing entries: pointers wrap twice, outputs arrive in order, COUNT steady at 1.
REQ-038 RESET asserted with COUNT=3 and push/pop active: COUNT=0, O_VALID=0 next cycle; BLOCKED cleared.

Source files
------------

// File: rtl/arr_mem_fifo_pkg.sv
// Shared types for arr_mem_fifo: two-element {x, y} entries packed into one storage word.
package arr_mem_fifo_pkg;

   localparam int unsigned ELEM_Y_W = 5;
   localparam int unsigned ELEM_W   = 1 + ELEM_Y_W;
   localparam int unsigned N_ELEM   = 2;
   localparam int unsigned WORD_W   = N_ELEM * ELEM_W;

   typedef struct packed {
      logic                x;
      logic [ELEM_Y_W-1:0] y;
   } elem_t;

   typedef elem_t [N_ELEM-1:0] elem_arr_t;
   typedef logic [WORD_W-1:0]  word_t;

   // Element i occupies bits [i*ELEM_W +: ELEM_W] with x in the lowest bit and y above it.
   function automatic word_t pack_word(elem_arr_t e);
      word_t w;
      w = '0;
      for (int i = 0; i < int'(N_ELEM); i++) begin
         w[i*ELEM_W +: ELEM_W] = {e[i].y, e[i].x};
      end
      return w;
   endfunction

   function automatic elem_arr_t unpack_word(word_t w);
      elem_arr_t e;
      e = '0;
      for (int i = 0; i < int'(N_ELEM); i++) begin
         e[i].x = w[i*ELEM_W];
         e[i].y = w[i*ELEM_W+1 +: ELEM_Y_W];
      end
      return e;
   endfunction

endpackage

// File: rtl/arr_mem_fifo_mem.sv
// Storage array for arr_mem_fifo: synchronous write, asynchronous read, no initialisation.
module arr_mem_fifo_mem
   import arr_mem_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  word_t             wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output word_t             rdata_o
);

   word_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/arr_mem_fifo.sv
// Valid/ready FIFO of two-element entries; occupancy held in COUNT, full/empty derived from it.
// Optional sticky BLOCKED output when ARR_MEM_FIFO_BLOCKED_EN is defined.
module arr_mem_fifo
   import arr_mem_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                I_VALID,
   output logic                I_READY,
   input  logic                I_DATA_0_X,
   input  logic                I_DATA_1_X,
   input  logic [ELEM_Y_W-1:0] I_DATA_0_Y,
   input  logic [ELEM_Y_W-1:0] I_DATA_1_Y,
   output logic                O_VALID,
   input  logic                O_READY,
   output logic                O_DATA_0_X,
   output logic                O_DATA_1_X,
   output logic [ELEM_Y_W-1:0] O_DATA_0_Y,
   output logic [ELEM_Y_W-1:0] O_DATA_1_Y,
   output logic [ADDR_W:0]     COUNT
`ifdef ARR_MEM_FIFO_BLOCKED_EN
   ,
   output logic                BLOCKED
`endif
);

   localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
   logic [ADDR_W:0]   count_d, count_q;
   logic              push, pop;
   elem_arr_t         in_elems, head_elems;
   word_t             wdata, rdata;

   // I_READY is held low during reset so nothing is accepted on a reset edge.
   assign I_READY = !RESET && (count_q != FullCount);
   assign O_VALID = (count_q != '0);
   assign push    = I_VALID && I_READY;
   assign pop     = O_VALID && O_READY;
   assign COUNT   = count_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + ADDR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (ADDR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      in_elems      = '0;
      in_elems[0].x = I_DATA_0_X;
      in_elems[0].y = I_DATA_0_Y;
      in_elems[1].x = I_DATA_1_X;
      in_elems[1].y = I_DATA_1_Y;
      wdata         = pack_word(in_elems);
      head_elems    = unpack_word(rdata);
   end

   assign O_DATA_0_X = head_elems[0].x;
   assign O_DATA_0_Y = head_elems[0].y;
   assign O_DATA_1_X = head_elems[1].x;
   assign O_DATA_1_Y = head_elems[1].y;

   arr_mem_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i   (CLK),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wdata),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

`ifdef ARR_MEM_FIFO_BLOCKED_EN
   logic blocked_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         blocked_q <= 1'b0;
      end else if (I_VALID && !I_READY) begin
         blocked_q <= 1'b1;
      end
   end

   assign BLOCKED = blocked_q;
`endif

endmodule

// File: tb/tb_arr_mem_fifo.sv
// Self-checking bench for arr_mem_fifo against a queue-based reference model.
// Also builds with ARR_MEM_FIFO_BLOCKED_EN to cover the BLOCKED flag.
module tb_arr_mem_fifo;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       I_VALID = 1'b0;
   logic       I_READY;
   logic       I_DATA_0_X = 1'b0, I_DATA_1_X = 1'b0;
   logic [4:0] I_DATA_0_Y = '0, I_DATA_1_Y = '0;
   logic       O_VALID;
   logic       O_READY = 1'b0;
   logic       O_DATA_0_X, O_DATA_1_X;
   logic [4:0] O_DATA_0_Y, O_DATA_1_Y;
   logic [2:0] COUNT;
`ifdef ARR_MEM_FIFO_BLOCKED_EN
   logic       BLOCKED;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain queue of packed words plus the sticky blocked bit.
   logic [11:0] mq[$];
   logic        m_blocked = 1'b0;

   arr_mem_fifo dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .I_VALID    (I_VALID),
      .I_READY    (I_READY),
      .I_DATA_0_X (I_DATA_0_X),
      .I_DATA_1_X (I_DATA_1_X),
      .I_DATA_0_Y (I_DATA_0_Y),
      .I_DATA_1_Y (I_DATA_1_Y),
      .O_VALID    (O_VALID),
      .O_READY    (O_READY),
      .O_DATA_0_X (O_DATA_0_X),
      .O_DATA_1_X (O_DATA_1_X),
      .O_DATA_0_Y (O_DATA_0_Y),
      .O_DATA_1_Y (O_DATA_1_Y),
      .COUNT      (COUNT)
`ifdef ARR_MEM_FIFO_BLOCKED_EN
      ,
      .BLOCKED    (BLOCKED)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [11:0] dut_word();
      return {O_DATA_1_Y, O_DATA_1_X, O_DATA_0_Y, O_DATA_0_X};
   endfunction

   // Drive one cycle of stimulus, advance one rising edge, update the model, settle 1 time unit.
   task automatic tick(input logic v, input logic [11:0] w, input logic ordy);
      bit acc, popm, blk;
      I_VALID    = v;
      I_DATA_0_X = w[0];
      I_DATA_0_Y = w[5:1];
      I_DATA_1_X = w[6];
      I_DATA_1_Y = w[11:7];
      O_READY    = ordy;
      #1;
      acc  = v && !RESET && (mq.size() != DEPTH);
      popm = ordy && !RESET && (mq.size() != 0);
      blk  = v && !acc;
      @(posedge CLK);
      if (RESET) begin
         mq.delete();
         m_blocked = 1'b0;
      end else begin
         if (popm) void'(mq.pop_front());
         if (acc) mq.push_back(w);
         if (blk) m_blocked = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick(1'b1, 12'h0, 1'b0);
      n_tests++;
      if (I_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_i_ready_during: got %b want 0", I_READY);
      end
      n_tests++;
      if (COUNT !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d want 0", COUNT);
      end
      n_tests++;
      if (O_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_o_valid: got %b want 0", O_VALID);
      end
      RESET = 1'b0;
      tick(1'b0, 12'h0, 1'b0);
      n_tests++;
      if (I_READY !== 1'b1 || COUNT !== 3'd0 || O_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got rdy=%b cnt=%0d vld=%b want 1 0 0", I_READY, COUNT, O_VALID);
      end
   endtask

   task automatic test_single_push();
      // 0_X=1, 0_Y=5'h15, 1_X=0, 1_Y=5'h0A
      tick(1'b1, {5'h0A, 1'b0, 5'h15, 1'b1}, 1'b0);
      I_VALID = 1'b0;
      #1;
      n_tests++;
      if (O_VALID !== 1'b1 || COUNT !== 3'd1) begin
         n_fail++;
         $display("FAIL single_push_valid: got vld=%b cnt=%0d want 1 1", O_VALID, COUNT);
      end
      n_tests++;
      if (O_DATA_0_X !== 1'b1 || O_DATA_0_Y !== 5'h15 || O_DATA_1_X !== 1'b0 ||
          O_DATA_1_Y !== 5'h0A) begin
         n_fail++;
         $display("FAIL single_push_data: got %b %h %b %h want 1 15 0 0a",
                  O_DATA_0_X, O_DATA_0_Y, O_DATA_1_X, O_DATA_1_Y);
      end
      n_tests++;
      if (dut_word() !== 12'h52B) begin
         n_fail++;
         $display("FAIL single_push_word: got %h want 52b", dut_word());
      end
      tick(1'b0, 12'h0, 1'b1);
      n_tests++;
      if (COUNT !== 3'd0 || O_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: got cnt=%0d vld=%b want 0 0", COUNT, O_VALID);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) tick(1'b1, 12'($urandom), 1'b0);
      n_tests++;
      if (COUNT !== 3'd4 || I_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: got cnt=%0d rdy=%b want 4 0", COUNT, I_READY);
      end
      tick(1'b1, 12'hFFF, 1'b0);
      n_tests++;
      if (COUNT !== 3'd4 || dut_word() !== mq[0]) begin
         n_fail++;
         $display("FAIL fill_fifth_rejected: got cnt=%0d head=%h want 4 %h", COUNT, dut_word(), mq[0]);
      end
`ifdef ARR_MEM_FIFO_BLOCKED_EN
      n_tests++;
      if (BLOCKED !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_blocked: got %b want 1", BLOCKED);
      end
`endif
   endtask

   task automatic test_full_pop_push();
      logic [11:0] w;
      w = 12'($urandom);
      tick(1'b1, w, 1'b1);
      n_tests++;
      if (COUNT !== 3'd3 || I_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pop_only: got cnt=%0d rdy=%b want 3 1", COUNT, I_READY);
      end
      tick(1'b1, w, 1'b0);
      n_tests++;
      if (COUNT !== 3'd4) begin
         n_fail++;
         $display("FAIL full_push_next: got cnt=%0d want 4", COUNT);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (O_VALID !== 1'b1 || dut_word() !== mq[0]) begin
            n_fail++;
            $display("FAIL full_drain[%0d]: got vld=%b data=%h want 1 %h", i, O_VALID, dut_word(),
                     mq[0]);
         end
         tick(1'b0, 12'h0, 1'b1);
      end
      n_tests++;
      if (dut_word() !== 12'hxxx && mq.size() != 0) n_fail++;
      if (COUNT !== 3'd0) begin
         n_fail++;
         $display("FAIL full_drained: got cnt=%0d want 0", COUNT);
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b1, 12'd0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         n_tests++;
         if (COUNT !== 3'd1 || dut_word() !== 12'(k - 1)) begin
            n_fail++;
            $display("FAIL stream[%0d]: got cnt=%0d data=%h want 1 %h", k, COUNT, dut_word(),
                     12'(k - 1));
         end
         if (k < 10) tick(1'b1, 12'(k), 1'b1);
         else tick(1'b0, 12'h0, 1'b1);
      end
      n_tests++;
      if (COUNT !== 3'd0 || O_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_end: got cnt=%0d vld=%b want 0 0", COUNT, O_VALID);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         tick(1'($urandom), 12'($urandom), 1'($urandom_range(0, 3) != 0));
         n_tests++;
         if (COUNT !== 3'(mq.size()) || O_VALID !== (mq.size() != 0) ||
             I_READY !== (mq.size() != DEPTH) || (mq.size() != 0 && dut_word() !== mq[0])) begin
            n_fail++;
            $display("FAIL random[%0d]: got cnt=%0d vld=%b rdy=%b data=%h want cnt=%0d head=%h",
                     i, COUNT, O_VALID, I_READY, dut_word(), mq.size(),
                     (mq.size() != 0) ? mq[0] : 12'h0);
         end
`ifdef ARR_MEM_FIFO_BLOCKED_EN
         n_tests++;
         if (BLOCKED !== m_blocked) begin
            n_fail++;
            $display("FAIL random_blocked[%0d]: got %b want %b", i, BLOCKED, m_blocked);
         end
`endif
      end
   endtask

   task automatic test_reset_mid();
      RESET = 1'b1;
      tick(1'b0, 12'h0, 1'b0);
      RESET = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 12'($urandom), 1'b0);
      tick(1'b0, 12'h0, 1'b1);
      n_tests++;
      if (COUNT !== 3'd3) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got cnt=%0d want 3", COUNT);
      end
      RESET = 1'b1;
      tick(1'b1, 12'($urandom), 1'b1);
      RESET = 1'b0;
      I_VALID = 1'b0;
      O_READY = 1'b0;
      #1;
      n_tests++;
      if (COUNT !== 3'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: got cnt=%0d vld=%b rdy=%b want 0 0 1", COUNT, O_VALID, I_READY);
      end
`ifdef ARR_MEM_FIFO_BLOCKED_EN
      n_tests++;
      if (BLOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_blocked: got %b want 0", BLOCKED);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill();
      test_full_pop_push();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
